// File: rtl/gba_rom_reader.sv
// GBA cartridge ROM bus initiator: one non-sequential address phase per 64K-halfword page,
// then sequential RD strobes, with each sampled halfword streamed out over valid/ready.
module gba_rom_reader #(
    parameter int T_ADDR    = 1,
    parameter int T_RD      = 4,
    parameter int T_RD_HIGH = 2
) (
    input  logic        CLK,
    input  logic        RESETB,
    input  logic        start,
    input  logic [23:0] start_addr,
    input  logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic [15:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        CS_N,
    output logic        RD_N,
    output logic        WR_N,
    output logic [7:0]  A_HI,
    output logic [15:0] AD_OUT,
    output logic        AD_OE,
    input  logic [15:0] AD_IN
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_HOLD, S_TURN, S_RDL, S_RDH, S_END
    } state_e;

    localparam logic [7:0] ADDR_LAST = 8'(T_ADDR - 1);
    localparam logic [7:0] RD_LAST   = 8'(T_RD - 1);
    localparam logic [7:0] RDH_LAST  = 8'(T_RD_HIGH - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        ad_oe_q, ad_oe_d;
    logic [15:0] ad_out_q, ad_out_d;
    logic [7:0]  a_hi_q, a_hi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        data_valid_q, data_valid_d;
    logic [15:0] data_out_q, data_out_d;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            addr_q       <= 24'd0;
            remaining_q  <= 16'd0;
            cs_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            ad_oe_q      <= 1'b0;
            ad_out_q     <= 16'd0;
            a_hi_q       <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            cs_n_q       <= cs_n_d;
            rd_n_q       <= rd_n_d;
            ad_oe_q      <= ad_oe_d;
            ad_out_q     <= ad_out_d;
            a_hi_q       <= a_hi_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        cs_n_d       = cs_n_q;
        rd_n_d       = rd_n_q;
        ad_oe_d      = ad_oe_q;
        ad_out_d     = ad_out_q;
        a_hi_d       = a_hi_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        data_valid_d = data_valid_q;
        data_out_d   = data_out_q;

        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != 16'd0) begin
                        addr_d      = start_addr;
                        remaining_d = length;
                        ad_out_d    = start_addr[15:0];
                        a_hi_d      = start_addr[23:16];
                        ad_oe_d     = 1'b1;
                        busy_d      = 1'b1;
                        cnt_d       = 8'd0;
                        state_d     = S_ADDR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    cs_n_d  = 1'b0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                ad_oe_d = 1'b0;
                state_d = S_TURN;
            end
            S_TURN: begin
                rd_n_d  = 1'b0;
                cnt_d   = 8'd0;
                state_d = S_RDL;
            end
            S_RDL: begin
                if (cnt_q == RD_LAST) begin
                    data_out_d   = AD_IN;
                    data_valid_d = 1'b1;
                    rd_n_d       = 1'b1;
                    addr_d       = addr_q + 24'd1;
                    remaining_d  = remaining_q - 16'd1;
                    cnt_d        = 8'd0;
                    state_d      = S_RDH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RDH: begin
                // The cartridge's internal counter only carries through the low 16 bits,
                // so a page crossing needs a fresh non-sequential address phase.
                if (cnt_q != RDH_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (!data_valid_q) begin
                    if (remaining_q == 16'd0) begin
                        state_d = S_END;
                    end else if (addr_q[15:0] == 16'd0) begin
                        cs_n_d   = 1'b1;
                        ad_out_d = addr_q[15:0];
                        a_hi_d   = addr_q[23:16];
                        ad_oe_d  = 1'b1;
                        cnt_d    = 8'd0;
                        state_d  = S_ADDR;
                    end else begin
                        rd_n_d  = 1'b0;
                        cnt_d   = 8'd0;
                        state_d = S_RDL;
                    end
                end
            end
            S_END: begin
                cs_n_d  = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign CS_N       = cs_n_q;
    assign RD_N       = rd_n_q;
    assign WR_N       = 1'b1;
    assign A_HI       = a_hi_q;
    assign AD_OUT     = ad_out_q;
    assign AD_OE      = ad_oe_q;

endmodule
